wb_cmd_master: RTL
==================

WB_CMD_MASTER -- requirements
Module: wb_cmd_master

Interface
REQ-001 The block SHALL have parameter TIMEOUT, default 1023, meaning idle bus cycles without request acceptance or ack before abort (10-bit counter).
REQ-002 i_clk  input  1  clock; all logic on rising edge.
REQ-003 i_reset  input  1  reset, synchronous, active-high.
REQ-004 i_cmd_valid  input  1  command present.
REQ-005 o_cmd_ready  output  1  command accepted when valid&&ready.
REQ-006 i_cmd_we  input  1  1=write burst (fill), 0=read burst.
REQ-007 i_cmd_addr  input  30  start word address.
REQ-008 i_cmd_data  input  32  write data, same word written every beat.
REQ-009 i_cmd_sel  input  4  byte selects, constant for burst.
REQ-010 i_cmd_len  input  8  beats minus one (0 -> 1 beat, 255 -> 256 beats).
REQ-011 o_wb_cyc, o_wb_stb, o_wb_we  output  1 each  pipelined Wishbone master controls.
REQ-012 o_wb_addr  output  30; o_wb_data  output  32; o_wb_sel  output  4.
REQ-013 i_wb_ack, i_wb_stall, i_wb_err  input  1 each  slave responses.
REQ-014 i_wb_data  input  32  slave read data.
REQ-015 o_rsp_valid  output  1  one-cycle pulse per read beat; o_rsp_data  output  32.
REQ-016 o_done  output  1  one-cycle pulse at burst end; o_err  output  1  qualifies o_done (bus error or timeout).

Function
REQ-017 States SHALL be IDLE, REQ, WAIT; all outputs registered.
REQ-018 IDLE: o_cmd_ready=1, o_wb_cyc=o_wb_stb=0; on valid&&ready latch command, set cyc=stb=1, o_wb_addr=i_cmd_addr, go REQ next cycle.
REQ-019 REQ: o_wb_stb=1; a request is accepted on each edge with stb&&!i_wb_stall; on acceptance o_wb_addr increments by 1 (mod 2^30, wrap 0x3FFFFFFF -> 0).
REQ-020 When the final (len+1)th request is accepted, stb SHALL drop next cycle and state go WAIT (cyc stays 1), unless all acks already received.
REQ-021 Acks SHALL be counted in REQ and WAIT; acks beyond accepted-request count are ignored.
REQ-022 When ack count reaches len+1, next cycle: cyc=stb=0, state IDLE, o_done=1, o_err=0.
REQ-023 Read ack: next cycle o_rsp_valid=1, o_rsp_data=i_wb_data sampled at ack; final read beat's o_rsp_valid coincides with o_done.
REQ-024 Writes SHALL never assert o_rsp_valid.
REQ-025 i_wb_err in REQ/WAIT: next cycle cyc=stb=0, IDLE, o_done=1, o_err=1; remaining beats abandoned; ack same cycle as err ignored.
REQ-026 Timeout counter resets on every accepted request or ack, else increments while cyc=1; reaching TIMEOUT aborts exactly as REQ-025.
REQ-027 o_cmd_ready=0 outside IDLE; a command may be accepted in the same cycle o_done pulses.
REQ-028 o_wb_we, o_wb_data, o_wb_sel SHALL hold latched values throughout the cycle; beat counters are 9 bits.

Reset
REQ-029 On i_reset, next cycle: state IDLE, cyc=stb=we=0, addr/data/sel=0, o_rsp_valid=o_done=o_err=0, o_cmd_ready=1, counters 0.
REQ-030 Reset mid-burst SHALL drop cyc immediately next cycle with no o_done pulse.

Verification
REQ-031 Read len=3 addr 0x100, slave no stall, ack 1 cycle after stb -> addrs 0x100..0x103 on consecutive cycles, 4 o_rsp_valid pulses, o_done with last, o_err=0.
REQ-032 Write len=0 data 0xDEADBEEF sel 0xF, stall 2 cycles -> stb held 3 cycles with stable addr/data, one ack, o_done=1, o_err=0, no o_rsp_valid.
REQ-033 Read len=1 at addr 0x3FFFFFFF -> second beat addr 0x00000000.
REQ-034 Read len=7, i_wb_err on 3rd ack -> cyc=0 next cycle, o_done=1, o_err=1, exactly 2 o_rsp_valid pulses.
REQ-035 Slave never acks, TIMEOUT=16 -> after 16 idle cycles cyc=0, o_done=1, o_err=1.
REQ-036 i_reset asserted mid read len=15 -> cyc=0 next cycle, no o_done; new command then accepted and completes normally.

Source files
------------

// File: rtl/wb_cmd_master.sv
// rtl/wb_cmd_master.sv - pipelined Wishbone burst master driven by a command port
module wb_cmd_master #(
    parameter int TIMEOUT = 1023
) (
    input  logic        i_clk,
    input  logic        i_reset,
    input  logic        i_cmd_valid,
    output logic        o_cmd_ready,
    input  logic        i_cmd_we,
    input  logic [29:0] i_cmd_addr,
    input  logic [31:0] i_cmd_data,
    input  logic [3:0]  i_cmd_sel,
    input  logic [7:0]  i_cmd_len,
    output logic        o_wb_cyc,
    output logic        o_wb_stb,
    output logic        o_wb_we,
    output logic [29:0] o_wb_addr,
    output logic [31:0] o_wb_data,
    output logic [3:0]  o_wb_sel,
    input  logic        i_wb_ack,
    input  logic        i_wb_stall,
    input  logic        i_wb_err,
    input  logic [31:0] i_wb_data,
    output logic        o_rsp_valid,
    output logic [31:0] o_rsp_data,
    output logic        o_done,
    output logic        o_err
);
    typedef enum logic [1:0] {IDLE = 2'd0, REQ = 2'd1, WAIT = 2'd2} state_t;

    // Abort fires on the edge that would make the idle count reach TIMEOUT.
    localparam logic [9:0] TMO_LAST = 10'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  len_q;
    logic [8:0]  req_cnt, ack_cnt;
    logic [9:0]  tmo_cnt;
    logic [8:0]  beats;
    logic        cmd_fire, req_fire, ack_fire, last_req, last_ack, tmo_hit, abort;
    logic        cyc_d, stb_d, ready_d, done_d, err_d, rsp_valid_d;

    assign beats    = {1'b0, len_q} + 9'd1;
    assign cmd_fire = (state_q == IDLE) && i_cmd_valid && o_cmd_ready;
    assign req_fire = (state_q == REQ) && o_wb_stb && !i_wb_stall;
    // An ack only counts against a request accepted on an earlier edge; an
    // ack arriving together with err is dropped because err ends the burst.
    assign ack_fire = (state_q != IDLE) && i_wb_ack && !i_wb_err && (ack_cnt < req_cnt);
    assign last_req = req_fire && ((req_cnt + 9'd1) == beats);
    assign last_ack = ack_fire && ((ack_cnt + 9'd1) == beats);
    assign tmo_hit  = (state_q != IDLE) && !req_fire && !ack_fire && (tmo_cnt == TMO_LAST);
    assign abort    = (state_q != IDLE) && (i_wb_err || tmo_hit);

    // State register
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decision
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (cmd_fire) state_d = REQ;
            REQ: begin
                if (abort || last_ack) state_d = IDLE;
                else if (last_req)     state_d = WAIT;
            end
            WAIT: if (abort || last_ack) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Next values of the registered control outputs
    always_comb begin
        cyc_d       = (state_d != IDLE);
        stb_d       = (state_d == REQ);
        ready_d     = (state_d == IDLE);
        done_d      = abort || last_ack;
        err_d       = abort;
        rsp_valid_d = ack_fire && !o_wb_we;
    end

    // Output registers, command latch, beat counters and idle timer
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            o_cmd_ready <= 1'b1;
            o_wb_cyc    <= 1'b0;
            o_wb_stb    <= 1'b0;
            o_wb_we     <= 1'b0;
            o_wb_addr   <= '0;
            o_wb_data   <= '0;
            o_wb_sel    <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_done      <= 1'b0;
            o_err       <= 1'b0;
            len_q       <= '0;
            req_cnt     <= '0;
            ack_cnt     <= '0;
            tmo_cnt     <= '0;
        end else begin
            o_cmd_ready <= ready_d;
            o_wb_cyc    <= cyc_d;
            o_wb_stb    <= stb_d;
            o_done      <= done_d;
            o_err       <= err_d;
            o_rsp_valid <= rsp_valid_d;
            if (rsp_valid_d) o_rsp_data <= i_wb_data;

            if (cmd_fire) begin
                o_wb_we   <= i_cmd_we;
                o_wb_addr <= i_cmd_addr;
                o_wb_data <= i_cmd_data;
                o_wb_sel  <= i_cmd_sel;
                len_q     <= i_cmd_len;
                req_cnt   <= '0;
                ack_cnt   <= '0;
            end else begin
                if (req_fire) begin
                    o_wb_addr <= o_wb_addr + 30'd1;
                    req_cnt   <= req_cnt + 9'd1;
                end
                if (ack_fire) ack_cnt <= ack_cnt + 9'd1;
            end

            if (cmd_fire || req_fire || ack_fire || !o_wb_cyc) tmo_cnt <= '0;
            else                                               tmo_cnt <= tmo_cnt + 10'd1;
        end
    end
endmodule
